// File: rtl/params_pkg.sv
// Shared AXI4 widths, response codes and the buffered beat format.
// No logic: constants and types only.
// beat_t carries the stream tlast tag alongside the data word.
package params_pkg;
  localparam int         AXI4_ADDR_W = 32;
  localparam int         AXI4_DATA_W = 32;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  // One buffered output beat: data plus the tlast tag computed at R time.
  typedef struct packed {
    logic                   last;
    logic [AXI4_DATA_W-1:0] data;
  } beat_t;
endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle (all five channels) with master/slave views.
// No logic: wires only.
// Standard valid/ready handshakes on every channel.
interface axi4_if;
  import params_pkg::*;
  logic                     awvalid, awready;
  logic [AXI4_ADDR_W-1:0]   awaddr;
  logic [7:0]               awlen;
  logic                     wvalid, wready, wlast;
  logic [AXI4_DATA_W-1:0]   wdata;
  logic [AXI4_DATA_W/8-1:0] wstrb;
  logic                     bvalid, bready;
  logic [1:0]               bresp;
  logic                     arvalid, arready;
  logic [AXI4_ADDR_W-1:0]   araddr;
  logic [7:0]               arlen;
  logic                     rvalid, rready, rlast;
  logic [AXI4_DATA_W-1:0]   rdata;
  logic [1:0]               rresp;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arlen, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );
  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arlen, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_stream_if.sv
// AXI4-Stream bundle with master/slave views.
// No logic: wires only.
// tvalid/tready handshake; tlast marks the end of a packet.
interface axi_stream_if;
  import params_pkg::*;
  logic                   tvalid, tready, tlast;
  logic [AXI4_DATA_W-1:0] tdata;

  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered storage, head word visible combinationally.
// Latency: a pushed word is readable the cycle after the push.
// Backpressure: push refused when full unless a pop happens in the same cycle.
// Ports: push/wdata in, pop/rdata out, full/empty/count status.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A pop when full frees the slot the simultaneous push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/axi4_to_stream.sv
// Reads num_bursts fixed-length AXI4 bursts from BASE_ADDR upward and replays them on AXI-Stream.
// Latency: an accepted R beat is presented on axis.tvalid the following cycle.
// Backpressure: AR waits for a whole burst of free buffer space; rready drops when the buffer is full.
// Ports: start/num_bursts in; busy/done/error status; axi4 read master; axis stream master.
module axi4_to_stream
  import params_pkg::*;
#(
  parameter int                     BURST_LEN  = 4,
  parameter int                     FIFO_DEPTH = 8,
  parameter logic [AXI4_ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] num_bursts,
  output logic        busy,
  output logic        done,
  output logic        error,
  axi4_if.master      axi4,
  axi_stream_if.master axis
);
  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_DRAIN} state_t;

  localparam int             BW           = $clog2(BURST_LEN);
  localparam int             CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0]  LAST_BEAT    = BW'(BURST_LEN - 1);
  localparam logic [CW-1:0]  AR_MAX_COUNT = CW'(FIFO_DEPTH - BURST_LEN);

  state_t                 state, state_nxt;
  logic [15:0]            remaining;
  logic [AXI4_ADDR_W-1:0] addr;
  logic [BW-1:0]          beat_cnt;
  logic                   ar_valid, r_ready, r_hs, pop, last_in_burst;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;
  beat_t                  push_beat, head_beat;

  assign r_hs          = axi4.rvalid && r_ready;
  assign last_in_burst = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    case (state)
      ST_IDLE:  if (start && num_bursts != 16'd0) state_nxt = ST_AR;
      // Only pops happen in ST_AR, so once free space suffices it stays
      // sufficient and arvalid cannot drop before arready.
      ST_AR: begin
        ar_valid = (fifo_count <= AR_MAX_COUNT);
        if (ar_valid && axi4.arready) state_nxt = ST_R;
      end
      ST_R: begin
        r_ready = !fifo_full;
        if (r_hs && last_in_burst)
          state_nxt = (remaining == 16'd1) ? ST_DRAIN : ST_AR;
      end
      ST_DRAIN: if (fifo_empty) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
      addr      <= BASE_ADDR;
      beat_cnt  <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          remaining <= num_bursts;
          addr      <= BASE_ADDR;
          beat_cnt  <= '0;
          error     <= 1'b0;
          done      <= (num_bursts == 16'd0);
        end
        // Burst boundaries follow beat_cnt; rlast is only cross-checked.
        ST_R: if (r_hs) begin
          if (axi4.rresp != RESP_OKAY || axi4.rlast != last_in_burst) error <= 1'b1;
          beat_cnt <= beat_cnt + 1'b1;
          if (last_in_burst) begin
            addr      <= addr + AXI4_ADDR_W'(BURST_LEN * 4);
            remaining <= remaining - 16'd1;
          end
        end
        ST_DRAIN: if (fifo_empty) done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign push_beat.data = axi4.rdata;
  assign push_beat.last = last_in_burst && (remaining == 16'd1);
  assign pop            = axis.tvalid && axis.tready;

  sync_fifo #(.WIDTH($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (r_hs),
    .wdata   (push_beat),
    .pop     (pop),
    .rdata   (head_beat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign busy = (state != ST_IDLE);

  assign axi4.arvalid = ar_valid;
  assign axi4.araddr  = addr;
  assign axi4.arlen   = 8'(BURST_LEN - 1);
  assign axi4.rready  = r_ready;
  assign axi4.awvalid = 1'b0;
  assign axi4.awaddr  = '0;
  assign axi4.awlen   = '0;
  assign axi4.wvalid  = 1'b0;
  assign axi4.wdata   = '0;
  assign axi4.wstrb   = '0;
  assign axi4.wlast   = 1'b0;
  assign axi4.bready  = 1'b1;

  // Head contents are undefined while empty, so tlast is gated.
  assign axis.tvalid = !fifo_empty;
  assign axis.tdata  = head_beat.data;
  assign axis.tlast  = !fifo_empty && head_beat.last;
endmodule

// File: tb/tb_axi4_to_stream.sv
// Bench for axi4_to_stream: behavioural AXI read slave, stream sink and reference queue.
module tb_axi4_to_stream;
  import params_pkg::*;

  localparam int          BL    = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_bursts = 16'd0;
  logic        busy, done, error;

  axi4_if       axi4_bus ();
  axi_stream_if axis_bus ();

  axi4_to_stream #(.BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .num_bursts (num_bursts),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .axi4       (axi4_bus),
    .axis       (axis_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  int n_assert = 0;
  int n_fail   = 0;

  // Test configuration (written by the sequencer between transfers)
  bit ar_rand = 0, r_gaps = 0;
  int t_mode = 1;                      // 0: tready low, 1: high, 2: random
  int err_burst = -1, err_beat = -1;   // where to inject rresp=SLVERR
  int lastx_burst = -1, lastx_beat = -1; // where to inject an early rlast
  int cur_nb = 0;

  // Reference model state
  logic [31:0] addr_q[$];
  exp_t        exp_q[$];
  int r_left = 0, r_beat = 0, r_burst = 0, tot_r = 0, tot_t = 0;
  int done_cycles = 0, ar_cycles = 0;
  bit hs_ar = 0, hs_r = 0, lat_pending = 0;
  bit p_arvalid = 0, p_arready = 0, p_tvalid = 0, p_tready = 0;
  logic [31:0] p_araddr = '0, p_tdata = '0;
  logic        p_tlast = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave, sink and scoreboard. Everything is decided at the falling edge;
  // handshakes computed here take effect at the following rising edge.
  initial begin
    axi4_bus.arready = 1'b0; axi4_bus.rvalid = 1'b0; axi4_bus.rdata = '0;
    axi4_bus.rresp = 2'b00;  axi4_bus.rlast = 1'b0;
    axi4_bus.awready = 1'b0; axi4_bus.wready = 1'b0;
    axi4_bus.bvalid = 1'b0;  axi4_bus.bresp = 2'b00;
    axis_bus.tready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        axi4_bus.arready = 1'b0; axi4_bus.rvalid = 1'b0; axis_bus.tready = 1'b0;
        r_left = 0; r_beat = 0; r_burst = 0;
        exp_q.delete();
        hs_ar = 0; hs_r = 0; lat_pending = 0;
        p_arvalid = 0; p_arready = 0; p_tvalid = 0; p_tready = 0;
      end else begin
        // retire handshakes of the rising edge just gone
        if (hs_ar) r_left += BL;
        if (hs_r) begin
          axi4_bus.rvalid = 1'b0;
          r_left--;
          r_beat++;
          if (r_beat == BL) begin r_beat = 0; r_burst++; end
        end
        // exp_q.size() is the model's buffer occupancy at this point
        if (done) done_cycles++;
        if (axi4_bus.arvalid) begin
          ar_cycles++;
          chk("ar_space", 64'((DEPTH - exp_q.size()) >= BL), 64'd1);
        end
        if (exp_q.size() == DEPTH) chk("rready_full", axi4_bus.rready, 0);
        chk("tvalid_occ", axis_bus.tvalid, 64'(exp_q.size() != 0));
        if (lat_pending) chk("r_to_t_latency", axis_bus.tvalid, 1);
        if (p_arvalid && !p_arready) begin
          chk("ar_hold_valid", axi4_bus.arvalid, 1);
          chk("ar_hold_addr", axi4_bus.araddr, p_araddr);
        end
        if (p_tvalid && !p_tready) begin
          chk("t_hold_data", axis_bus.tdata, p_tdata);
          chk("t_hold_last", axis_bus.tlast, p_tlast);
        end
        // drive
        axi4_bus.arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!axi4_bus.rvalid && r_left > 0 && (!r_gaps || $urandom_range(0, 3) != 0)) begin
          axi4_bus.rvalid = 1'b1;
          axi4_bus.rdata  = $urandom;
          axi4_bus.rresp  = (r_burst == err_burst && r_beat == err_beat) ? 2'b10 : 2'b00;
          axi4_bus.rlast  = (r_beat == BL - 1) ||
                            (r_burst == lastx_burst && r_beat == lastx_beat);
        end
        axis_bus.tready = (t_mode == 0) ? 1'b0 : (t_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        // handshakes at the next rising edge
        if (axis_bus.tvalid && axis_bus.tready) begin
          chk("t_extra_beat", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("tdata", axis_bus.tdata, e.d);
            chk("tlast", axis_bus.tlast, e.l);
          end
          tot_t++;
        end
        hs_ar = axi4_bus.arvalid && axi4_bus.arready;
        if (hs_ar) begin
          addr_q.push_back(axi4_bus.araddr);
          chk("arlen", axi4_bus.arlen, BL - 1);
        end
        hs_r = axi4_bus.rvalid && axi4_bus.rready;
        if (hs_r) begin
          exp_t e;
          e.d = axi4_bus.rdata;
          e.l = (tot_r == cur_nb * BL - 1);
          exp_q.push_back(e);
          tot_r++;
        end
        lat_pending = hs_r;
        p_arvalid = axi4_bus.arvalid; p_arready = axi4_bus.arready; p_araddr = axi4_bus.araddr;
        p_tvalid = axis_bus.tvalid;   p_tready = axis_bus.tready;
        p_tdata = axis_bus.tdata;     p_tlast = axis_bus.tlast;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_start(input int nb);
    start = 1'b1;
    num_bursts = 16'(nb);
    step();
    start = 1'b0;
  endtask

  task automatic begin_xfer(input int nb);
    addr_q.delete();
    tot_r = 0; tot_t = 0; done_cycles = 0; ar_cycles = 0;
    r_beat = 0; r_burst = 0;
    cur_nb = nb;
    drive_start(nb);
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      step();
      i++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic check_xfer(input int nb, input logic exp_err);
    chk("ar_count", addr_q.size(), nb);
    for (int i = 0; i < addr_q.size() && i < nb; i++)
      chk("araddr", addr_q[i], BASE + 32'(i * BL * 4));
    chk("beats_out", tot_t, nb * BL);
    chk("model_left", exp_q.size(), 0);
    chk("done_once", done_cycles, 1);
    chk("error", error, exp_err);
    chk("busy_end", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_done"},    done, 0);
    chk({tag, "_error"},   error, 0);
    chk({tag, "_arvalid"}, axi4_bus.arvalid, 0);
    chk({tag, "_rready"},  axi4_bus.rready, 0);
    chk({tag, "_tvalid"},  axis_bus.tvalid, 0);
    chk({tag, "_tlast"},   axis_bus.tlast, 0);
  endtask

  initial begin
    int nb, i;
    reset_n = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();
    check_all_zero("post_reset");

    // two bursts, everything ready; a second start while busy is ignored
    t_mode = 1;
    begin_xfer(2);
    chk("busy_start", busy, 1);
    step();
    chk("busy_mid", busy, 1);
    drive_start(5);
    wait_done(200);
    repeat (3) step();
    check_xfer(2, 1'b0);

    // sink stalled: buffer fills, third AR waits, then everything drains
    t_mode = 0;
    begin_xfer(3);
    repeat (60) step();
    chk("stall_ar_count", addr_q.size(), 2);
    chk("stall_occupancy", exp_q.size(), DEPTH);
    chk("stall_rready", axi4_bus.rready, 0);
    chk("stall_arvalid", axi4_bus.arvalid, 0);
    chk("stall_beats_out", tot_t, 0);
    t_mode = 1;
    wait_done(200);
    repeat (3) step();
    check_xfer(3, 1'b0);

    // SLVERR on the second beat of the first burst
    err_burst = 0; err_beat = 1;
    begin_xfer(2);
    wait_done(200);
    repeat (3) step();
    check_xfer(2, 1'b1);
    repeat (5) step();
    chk("error_sticky", error, 1);
    err_burst = -1; err_beat = -1;
    begin_xfer(1);
    chk("error_cleared", error, 0);
    wait_done(200);
    repeat (3) step();
    check_xfer(1, 1'b0);

    // early rlast on the third beat of the first burst
    lastx_burst = 0; lastx_beat = 2;
    begin_xfer(2);
    wait_done(200);
    repeat (3) step();
    check_xfer(2, 1'b1);
    lastx_burst = -1; lastx_beat = -1;

    // zero bursts: done the cycle after start, no AXI traffic
    begin_xfer(0);
    chk("zero_done_pulse", done, 1);
    step();
    chk("zero_done_low", done, 0);
    repeat (3) step();
    chk("zero_arvalid_cycles", ar_cycles, 0);
    chk("zero_done_once", done_cycles, 1);
    chk("zero_busy", busy, 0);

    // randomized handshakes
    for (int k = 0; k < 3; k++) begin
      ar_rand = 1; r_gaps = 1; t_mode = 2;
      nb = $urandom_range(3, 6);
      begin_xfer(nb);
      wait_done(2000);
      repeat (3) step();
      check_xfer(nb, 1'b0);
    end

    // reset in the middle of the second burst with the buffer half full
    ar_rand = 0; r_gaps = 1; t_mode = 0;
    begin_xfer(4);
    i = 0;
    while (exp_q.size() < 5 && i < 200) begin
      step();
      i++;
    end
    chk("half_full_reached", 64'(exp_q.size() >= 5), 64'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) step();
    reset_n = 1'b1;
    r_gaps = 0; t_mode = 1;
    step();
    begin_xfer(1);
    wait_done(200);
    repeat (3) step();
    check_xfer(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1);
  end
endmodule
